// File: rtl/secuencia_lectura_rtc.sv
// Read sequencer for the external RTC on the multiplexed address/data bus.
// Walks indices 1..N_REG, runs one multiplexed read cycle per index and latches the returned byte.
module secuencia_lectura_rtc #(
    parameter int T_PHASE = 4,
    parameter int N_REG   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] dir,
    output logic [4:0] cont,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in,
    output logic       cs_n,
    output logic       ad_sel,
    output logic       wr_n,
    output logic       rd_n,
    output logic       busy,
    output logic       done,
    output logic [7:0] seg,
    output logic [7:0] min,
    output logic [7:0] hora,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] anio
);
    localparam int              CW        = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
    localparam logic [CW-1:0]   PH_LAST   = CW'(T_PHASE - 1);
    localparam logic [4:0]      CONT_LAST = 5'(N_REG);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SETUP     = 3'd1;
    localparam logic [2:0] ADDR_WR   = 3'd2;
    localparam logic [2:0] ADDR_HOLD = 3'd3;
    localparam logic [2:0] DATA_RD   = 3'd4;
    localparam logic [2:0] RECOVER   = 3'd5;
    localparam logic [2:0] DONE      = 3'd6;

    logic [2:0]    state;
    logic [CW-1:0] ph;
    logic          ph_end;

    assign ph_end = (ph == PH_LAST);

    // Strobes are set on the edge that enters each state so every output stays registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ph     <= '0;
            cont   <= 5'd0;
            ad_out <= 8'h00;
            ad_oe  <= 1'b0;
            cs_n   <= 1'b1;
            ad_sel <= 1'b0;
            wr_n   <= 1'b1;
            rd_n   <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            seg    <= 8'h00;
            min    <= 8'h00;
            hora   <= 8'h00;
            dia    <= 8'h00;
            mes    <= 8'h00;
            anio   <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cont  <= 5'd1;
                        busy  <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    ad_out <= dir;
                    ad_oe  <= 1'b1;
                    ad_sel <= 1'b0;
                    cs_n   <= 1'b0;
                    wr_n   <= 1'b0;
                    ph     <= '0;
                    state  <= ADDR_WR;
                end
                ADDR_WR: begin
                    if (ph_end) begin
                        ph    <= '0;
                        cs_n  <= 1'b1;
                        wr_n  <= 1'b1;
                        state <= ADDR_HOLD;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                ADDR_HOLD: begin
                    if (ph_end) begin
                        ph     <= '0;
                        ad_oe  <= 1'b0;
                        ad_sel <= 1'b1;
                        cs_n   <= 1'b0;
                        rd_n   <= 1'b0;
                        state  <= DATA_RD;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                DATA_RD: begin
                    if (ph_end) begin
                        ph     <= '0;
                        cs_n   <= 1'b1;
                        rd_n   <= 1'b1;
                        ad_sel <= 1'b0;
                        state  <= RECOVER;
                        case (cont)
                            5'd1:    seg  <= ad_in;
                            5'd2:    min  <= ad_in;
                            5'd3:    hora <= ad_in;
                            5'd4:    dia  <= ad_in;
                            5'd5:    mes  <= ad_in;
                            5'd6:    anio <= ad_in;
                            default: ;
                        endcase
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                RECOVER: begin
                    if (ph_end) begin
                        ph <= '0;
                        if (cont == CONT_LAST) begin
                            cont  <= 5'd0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            cont  <= cont + 5'd1;
                            state <= SETUP;
                        end
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_secuencia_lectura_rtc.sv
// Bench for secuencia_lectura_rtc: two instances (T_PHASE=4 and T_PHASE=1) against a
// cycle-position model of the read sequence and a bus model that answers each read.
module tb_secuencia_lectura_rtc;
    logic       clk = 1'b0;
    logic       reset;
    logic       start  [2];
    logic [7:0] dir    [2];
    logic [7:0] ad_in  [2];
    logic [7:0] ad_out [2];
    logic [4:0] cont   [2];
    logic       ad_oe  [2];
    logic       cs_n   [2];
    logic       ad_sel [2];
    logic       wr_n   [2];
    logic       rd_n   [2];
    logic       busy   [2];
    logic       done   [2];
    logic [7:0] seg [2], min [2], hora [2], dia [2], mes [2], anio [2];

    int errors = 0;
    int checks = 0;
    int mode [2];
    logic [7:0] pre  [2];
    logic [7:0] expr [2][6];

    always #5 clk = ~clk;

    function automatic logic [7:0] dec(input logic [4:0] c);
        if (c >= 5'd1 && c <= 5'd6) return 8'h20 + {3'b000, c};
        return 8'h00;
    endfunction

    assign dir[0] = dec(cont[0]);
    assign dir[1] = dec(cont[1]);

    secuencia_lectura_rtc #(.T_PHASE(4), .N_REG(6)) dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .dir(dir[0]), .cont(cont[0]),
        .ad_out(ad_out[0]), .ad_oe(ad_oe[0]), .ad_in(ad_in[0]), .cs_n(cs_n[0]),
        .ad_sel(ad_sel[0]), .wr_n(wr_n[0]), .rd_n(rd_n[0]), .busy(busy[0]), .done(done[0]),
        .seg(seg[0]), .min(min[0]), .hora(hora[0]), .dia(dia[0]), .mes(mes[0]), .anio(anio[0])
    );

    secuencia_lectura_rtc #(.T_PHASE(1), .N_REG(6)) dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .dir(dir[1]), .cont(cont[1]),
        .ad_out(ad_out[1]), .ad_oe(ad_oe[1]), .ad_in(ad_in[1]), .cs_n(cs_n[1]),
        .ad_sel(ad_sel[1]), .wr_n(wr_n[1]), .rd_n(rd_n[1]), .busy(busy[1]), .done(done[1]),
        .seg(seg[1]), .min(min[1]), .hora(hora[1]), .dia(dia[1]), .mes(mes[1]), .anio(anio[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] ctrl(input int i);
        return {52'd0, cont[i], cs_n[i], wr_n[i], rd_n[i], ad_oe[i], ad_sel[i], busy[i], done[i]};
    endfunction

    function automatic logic [63:0] regs(input int i);
        return {16'd0, seg[i], min[i], hora[i], dia[i], mes[i], anio[i]};
    endfunction

    function automatic logic [63:0] exp_regs(input int i);
        return {16'd0, expr[i][0], expr[i][1], expr[i][2], expr[i][3], expr[i][4], expr[i][5]};
    endfunction

    task automatic clear_exp();
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 6; k++) expr[i][k] = 8'h00;
    endtask

    // One clock: bus model drives ad_in before the edge, outputs sampled 1 unit after it.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            ad_in[i] = (mode[i] == 0) ? ad_out[i] + 8'h10 : 8'($urandom);
            pre[i]   = ad_in[i];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("proto_wr_rd_overlap", {63'd0, (!wr_n[i] && !rd_n[i])}, 64'd0);
            chk("proto_drive_while_read", {63'd0, (ad_oe[i] && !rd_n[i])}, 64'd0);
        end
    endtask

    task automatic idle_chk(input int i, input string tag);
        chk({tag, "_ctrl"}, ctrl(i), {52'd0, 5'd0, 7'b1110000});
        chk({tag, "_regs"}, regs(i), exp_regs(i));
    endtask

    // Edge c counts from the edge that samples start (c=0). Position r inside a byte of
    // B=1+4T cycles: 0 setup, 1..T address write, T+1..2T hold, 2T+1..3T read, 3T+1..4T recover.
    task automatic run_seq(input int i, input int hold, input int abort_at);
        int t, b, n, k, r;
        logic wrl, rdl;
        logic [63:0] e;
        t = (i == 0) ? 4 : 1;
        b = 1 + 4 * t;
        n = 6 * b;
        start[i] = 1'b1;
        for (int c = 0; c <= n + 1; c++) begin
            tick();
            if (c == 0 && hold == 0) start[i] = 1'b0;
            if (c < n) begin
                k = c / b + 1;
                r = c % b;
                if (r == 3 * t + 1) expr[i][k-1] = pre[i];
                wrl = (r >= 1 && r <= t);
                rdl = (r >= 2 * t + 1 && r <= 3 * t);
                e = {52'd0, 5'(k), !(wrl || rdl), !wrl, !rdl, (r >= 1 && r <= 2 * t), rdl, 1'b1, 1'b0};
                if (r >= 1 && r <= 2 * t) chk("addr_on_bus", {56'd0, ad_out[i]}, {56'd0, 8'h20 + 8'(k)});
            end else if (c == n) begin
                e = {52'd0, 5'd0, 7'b1110001};
            end else begin
                e = {52'd0, 5'd0, 7'b1110000};
            end
            chk("seq_ctrl", ctrl(i), e);
            chk("seq_regs", regs(i), exp_regs(i));
            if (abort_at > 0 && c == abort_at) break;
        end
        if (abort_at > 0) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            clear_exp();
            idle_chk(i, "abort_reset");
            chk("abort_bus_released", {62'd0, ad_oe[i], ad_sel[i]}, 64'd0);
            for (int c = 0; c < 120; c++) begin
                tick();
                chk("abort_no_done", {63'd0, done[i]}, 64'd0);
                idle_chk(i, "abort_idle");
            end
        end
        if (hold != 0) begin
            tick();
            chk("hold_second_start", {62'd0, cont[i] == 5'd1, busy[i]}, 64'd3);
            start[i] = 1'b0;
            reset = 1'b1;
            tick();
            reset = 1'b0;
            clear_exp();
            idle_chk(i, "hold_reset");
        end
    endtask

    initial begin
        reset = 1'b1;
        start[0] = 1'b0;
        start[1] = 1'b0;
        ad_in[0] = 8'h00;
        ad_in[1] = 8'h00;
        mode[0] = 1;
        mode[1] = 1;
        clear_exp();
        repeat (3) tick();
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            idle_chk(0, "reset_idle0");
            idle_chk(1, "reset_idle1");
        end

        mode[0] = 0;
        run_seq(0, 0, 0);
        chk("echo_regs_t4", regs(0), {16'd0, 48'h313233343536});

        mode[0] = 1;
        run_seq(0, 1, 0);

        run_seq(0, 0, 2 * 17 + 2 * 4 + 2);

        mode[1] = 0;
        run_seq(1, 0, 0);
        chk("echo_regs_t1", regs(1), {16'd0, 48'h313233343536});

        mode[1] = 1;
        run_seq(1, 0, 0);
        repeat (5) begin
            tick();
            idle_chk(1, "final_idle1");
            idle_chk(0, "final_idle0");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/secuencia_lectura_rtc.md
Name: secuencia_lectura_rtc

Overview:
Read sequencer for the external RTC on the multiplexed address/data bus. On a start pulse it steps a 5-bit index from 1 to 6. The index drives the read-address decoder, which returns RTC register addresses 0x21..0x26 combinationally. For each index the block runs one Intel-style multiplexed read cycle and latches the returned byte into the matching time/date register. It sits between the periodic refresh tick and the display/format logic that consumes the six registers.

Parameters:
T_PHASE, 4, clock cycles per bus phase (minimum 1); sets cs_n/wr_n/rd_n pulse widths.
N_REG, 6, number of RTC registers read per sequence; fixed at 6, matching the decoder table.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to read all registers; sampled only in IDLE
dir  in  8  RTC address from the read-address decoder for the current cont
cont  out  5  index to the decoder; 0 when idle, 1..6 during a sequence
ad_out  out  8  bus drive value (address)
ad_oe  out  1  1 = block drives ad_out onto the bus
ad_in  in  8  bus read value
cs_n  out  1  RTC chip select, active low
ad_sel  out  1  0 = address phase, 1 = data phase (A/D line)
wr_n  out  1  write strobe, active low (latches the address)
rd_n  out  1  read strobe, active low
busy  out  1  high from SETUP through RECOVER of the last byte
done  out  1  one-cycle pulse when all six registers are updated
seg, min, hora, dia, mes, anio  out  8 each  latched RTC bytes

Behaviour:
- All outputs are registered. Reset values: cont=0, ad_out=0, ad_oe=0, cs_n=1, ad_sel=0, wr_n=1, rd_n=1, busy=0, done=0, all six data registers=0x00, FSM in IDLE, phase counter=0.
- States: IDLE, SETUP, ADDR_WR, ADDR_HOLD, DATA_RD, RECOVER, DONE. The phase counter runs 0..T_PHASE-1 in each timed state.
- IDLE: bus deasserted, cont=0. If start=1, set cont=1 and go to SETUP. Otherwise stay in IDLE.
- SETUP (1 cycle): dir is valid for the current cont. Latch dir into ad_out, set ad_oe=1 and ad_sel=0, then go to ADDR_WR.
- ADDR_WR (T_PHASE cycles): cs_n=0, wr_n=0, address driven on the bus.
- ADDR_HOLD (T_PHASE cycles): wr_n=1, cs_n=1, address still driven (ad_oe=1).
- DATA_RD (T_PHASE cycles): ad_oe=0, ad_sel=1, cs_n=0, rd_n=0. On the clock edge that leaves DATA_RD, ad_in is written into the register for cont: 1 to seg, 2 to min, 3 to hora, 4 to dia, 5 to mes, 6 to anio.
- RECOVER (T_PHASE cycles): cs_n=1, rd_n=1, ad_sel=0, bus released.
  - On exit with cont<6: cont increments and the FSM goes to SETUP.
  - On exit with cont=6: cont=0 and the FSM goes to DONE.
- DONE (1 cycle): done=1, busy=0, then go to IDLE.
- Per-byte time is 1+4*T_PHASE cycles. The sequence is N = 6*(1+4*T_PHASE) cycles (102 for T_PHASE=4). done is high between edges N and N+1, counted from the edge that sampled start.
- Data registers change only at the DATA_RD exit edge for their own index and hold their value at all other times.
- start outside IDLE is ignored; no queuing. start during DONE is also ignored.
- cs_n is never low with both wr_n and rd_n high except at T_PHASE boundaries. wr_n and rd_n are never low together. ad_oe=1 never coincides with rd_n=0.
- Reset mid-sequence: the next edge applies reset values, the bus is released, and registers return to 0x00. No partial done pulse is produced.
- dir is used only in SETUP. Its value while cont=0 is don't-care.

Test Plan:
- Reset, then idle 20 cycles → cont=0, cs_n=wr_n=rd_n=1, ad_oe=0, busy=0, all registers 0x00.
- T_PHASE=4, bus model returns addr+0x10; pulse start → ad_out sequence 0x21..0x26. Each wr_n low pulse and rd_n low pulse lasts 4 cycles. Result: seg=0x31, min=0x32, hora=0x33, dia=0x34, mes=0x35, anio=0x36. done is high exactly 102 cycles after start.
- start held high for the whole sequence → exactly one sequence runs. A second sequence begins only after return to IDLE, with no start accepted in DONE.
- Assert reset during DATA_RD of cont=3 → next cycle all bus strobes high, ad_oe=0, cont=0, registers 0x00, done never pulses.
- T_PHASE=1 → per-byte time 5 cycles and done at cycle 30. The bus-protocol assertions (no wr_n/rd_n overlap, no drive while reading) hold throughout.
- Change ad_in outside the DATA_RD exit edge → registers capture only the value present at that exit edge.
